// File: rtl/alu_seq_unit.sv
// Handshaked sequential 8-bit ALU with a 16-bit result; MUL and DIV iterate over 8 cycles.
// Optional build macro ALU_DIV_REM_EN: DIV returns {remainder, quotient} instead of {8'h00, quotient}.
module alu_seq_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    input  logic [3:0]  req_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and the producer holds its payload stable until that edge.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    localparam logic [3:0] SEL_ADD = 4'b0000;
    localparam logic [3:0] SEL_SUB = 4'b0001;
    localparam logic [3:0] SEL_MUL = 4'b0010;
    localparam logic [3:0] SEL_DIV = 4'b0011;
    localparam logic [3:0] SEL_AND = 4'b0100;
    localparam logic [3:0] SEL_OR  = 4'b0101;
    localparam logic [3:0] SEL_NOT = 4'b0110;
    localparam logic [3:0] SEL_XOR = 4'b0111;
    localparam logic [3:0] SEL_SHL = 4'b1000;
    localparam logic [3:0] SEL_SHR = 4'b1001;

    state_t      state;
    state_t      state_next;
    logic [2:0]  cnt;
    logic        is_div;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [15:0] acc;
    logic [15:0] acc_next;
    logic [15:0] long_res;

    logic        accept;
    logic        req_long;
    logic [15:0] short_res;
    logic        short_err;

    logic [15:0] mul_term;
    logic [8:0]  div_trial;
    logic        div_ge;
    logic [7:0]  div_diff;
    logic [7:0]  div_rem;

    assign accept   = req_valid && (state == IDLE);
    assign req_long = (req_sel == SEL_MUL) || ((req_sel == SEL_DIV) && (req_b != 8'h00));

    // Results for everything that finishes in the accept cycle, including both error cases.
    always_comb begin
        short_res = 16'h0000;
        short_err = 1'b0;
        case (req_sel)
            SEL_ADD: short_res = {8'h00, req_a} + {8'h00, req_b};
            SEL_SUB: short_res = {8'h00, req_a} - {8'h00, req_b};
            SEL_DIV: begin
`ifdef ALU_DIV_REM_EN
                short_res = {req_a, 8'hFF};
`else
                short_res = 16'h00FF;
`endif
                short_err = 1'b1;
            end
            SEL_AND: short_res = {8'h00, req_a & req_b};
            SEL_OR:  short_res = {8'h00, req_a | req_b};
            SEL_NOT: short_res = {8'h00, ~req_a};
            SEL_XOR: short_res = {8'h00, req_a ^ req_b};
            SEL_SHL: short_res = (req_b >= 8'd16) ? 16'h0000 : ({8'h00, req_a} << req_b[3:0]);
            SEL_SHR: short_res = (req_b >= 8'd8) ? 16'h0000 : ({8'h00, req_a} >> req_b[2:0]);
            SEL_MUL: short_res = 16'h0000;
            default: begin
                short_res = 16'h0000;
                short_err = 1'b1;
            end
        endcase
    end

    // One iteration step: shift-add for MUL; restoring division with acc = {remainder, dividend/quotient}.
    always_comb begin
        mul_term  = op_b[cnt] ? ({8'h00, op_a} << cnt) : 16'h0000;
        div_trial = {acc[15:8], acc[7]};
        div_ge    = div_trial >= {1'b0, op_b};
        div_diff  = div_trial[7:0] - op_b;
        div_rem   = div_ge ? div_diff : div_trial[7:0];
        acc_next  = is_div ? {div_rem, acc[6:0], div_ge} : (acc + mul_term);
`ifdef ALU_DIV_REM_EN
        long_res  = acc_next;
`else
        long_res  = is_div ? {8'h00, acc_next[7:0]} : acc_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = req_long ? BUSY : DONE;
            BUSY: if (cnt == 3'd7) state_next = DONE;
            DONE: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == DONE);
    end

    // Datapath; rsp_data/rsp_err only change on accept of a short op or on the last BUSY step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= 3'd0;
            is_div   <= 1'b0;
            op_a     <= 8'h00;
            op_b     <= 8'h00;
            acc      <= 16'h0000;
            rsp_data <= 16'h0000;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a   <= req_a;
                        op_b   <= req_b;
                        cnt    <= 3'd0;
                        is_div <= (req_sel == SEL_DIV);
                        if (req_long) begin
                            acc <= (req_sel == SEL_DIV) ? {8'h00, req_a} : 16'h0000;
                        end else begin
                            rsp_data <= short_res;
                            rsp_err  <= short_err;
                        end
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        rsp_data <= long_res;
                        rsp_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed, table-driven bench for alu_seq_unit; expected values are hand-computed.
// Build-dependent DIV expectations follow ALU_DIV_REM_EN.
module tb_alu_seq_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic [3:0]  req_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

`ifdef ALU_DIV_REM_EN
    localparam logic [15:0] EXP_DIV_3_5   = 16'h0300;
    localparam logic [15:0] EXP_DIV_200_7 = 16'h041C;
    localparam logic [15:0] EXP_DIV_9_0   = 16'h09FF;
`else
    localparam logic [15:0] EXP_DIV_3_5   = 16'h0000;
    localparam logic [15:0] EXP_DIV_200_7 = 16'h001C;
    localparam logic [15:0] EXP_DIV_9_0   = 16'h00FF;
`endif

    typedef struct {
        logic [3:0]  sel;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] d;
        logic        e;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    alu_seq_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one request from IDLE, waits (bounded) for the response, then completes the handshake.
    task automatic run_op(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] d, output logic e, output int lat);
        @(negedge clk);
        chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_sel   = sel;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        d = rsp_data;
        e = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] d;
        logic        e;
        int          lat;
        logic [15:0] held;
        logic [15:0] exp_d;
        int          pulses;

        vecs[0]  = '{4'b0000, 8'd3,   8'd5,   16'h0008,      1'b0, 1};
        vecs[1]  = '{4'b0001, 8'd3,   8'd5,   16'hFFFE,      1'b0, 1};
        vecs[2]  = '{4'b0010, 8'd3,   8'd5,   16'h000F,      1'b0, 9};
        vecs[3]  = '{4'b0011, 8'd3,   8'd5,   EXP_DIV_3_5,   1'b0, 9};
        vecs[4]  = '{4'b0100, 8'd3,   8'd5,   16'h0001,      1'b0, 1};
        vecs[5]  = '{4'b0101, 8'd3,   8'd5,   16'h0007,      1'b0, 1};
        vecs[6]  = '{4'b0110, 8'd3,   8'd5,   16'h00FC,      1'b0, 1};
        vecs[7]  = '{4'b0111, 8'd3,   8'd5,   16'h0006,      1'b0, 1};
        vecs[8]  = '{4'b1000, 8'd3,   8'd5,   16'h0060,      1'b0, 1};
        vecs[9]  = '{4'b1001, 8'd3,   8'd5,   16'h0000,      1'b0, 1};
        vecs[10] = '{4'b0011, 8'd200, 8'd7,   EXP_DIV_200_7, 1'b0, 9};
        vecs[11] = '{4'b0011, 8'd9,   8'd0,   EXP_DIV_9_0,   1'b1, 1};
        vecs[12] = '{4'b1100, 8'd9,   8'd4,   16'h0000,      1'b1, 1};
        vecs[13] = '{4'b1000, 8'hFF,  8'd16,  16'h0000,      1'b0, 1};

        // Reset
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = 8'h00;
        req_b     = 8'h00;
        req_sel   = 4'h0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_data",  {16'd0, rsp_data},  32'd0);
        chk("reset_rsp_err",   {31'd0, rsp_err},   32'd0);
        rst_n = 1'b1;

        run_op(4'b0000, 8'd10, 8'd7, d, e, lat);
        chk("add_10_7_data", {16'd0, d}, 32'd17);
        chk("add_10_7_lat",  lat, 32'd1);

        // Vector table
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(vecs[i].d);
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, d, e, lat);
            exp_d = exp_q.pop_front();
            chk($sformatf("vec%0d_data", i), {16'd0, d}, {16'd0, exp_d});
            chk($sformatf("vec%0d_err", i),  {31'd0, e}, {31'd0, vecs[i].e});
            chk($sformatf("vec%0d_lat", i),  lat, vecs[i].lat);
        end

        // MUL 255x255 with request churn during BUSY, then backpressure
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_a     = 8'd255;
        req_b     = 8'd255;
        req_sel   = 4'b0010;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("busy%0d_req_ready", i), {31'd0, req_ready}, 32'd0);
            chk($sformatf("busy%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd0);
            req_a   = 8'($urandom_range(0, 255));
            req_b   = 8'($urandom_range(0, 255));
            req_sel = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        chk("mul_ff_valid", {31'd0, rsp_valid}, 32'd1);
        chk("mul_ff_data",  {16'd0, rsp_data},  32'h0000FE01);
        chk("mul_ff_err",   {31'd0, rsp_err},   32'd0);
        held = rsp_data;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_valid", i),     {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("bp%0d_data", i),      {16'd0, rsp_data},  32'h0000FE01);
            chk($sformatf("bp%0d_req_ready", i), {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("hs_req_ready", {31'd0, req_ready}, 32'd1);
        chk("hs_data_held", {16'd0, rsp_data},  {16'd0, held});

        // Reset during BUSY of a MUL
        @(negedge clk);
        req_valid = 1'b1;
        req_a     = 8'd20;
        req_b     = 8'd30;
        req_sel   = 4'b0010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_rsp_data",  {16'd0, rsp_data},  32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) pulses++;
        end
        chk("midrst_no_rsp", pulses, 32'd0);

        run_op(4'b0000, 8'd100, 8'd200, d, e, lat);
        chk("post_rst_add_data", {16'd0, d}, 32'h0000012C);
        chk("post_rst_add_err",  {31'd0, e}, 32'd0);
        chk("post_rst_add_lat",  lat, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
